scalar_mult_ctrl: RTL and testbench
===================================

SCALAR_MULT_CTRL -- requirements
Module: scalar_mult_ctrl

Interface
REQ-001 SHALL have parameter W, default 256, meaning coordinate width in bits.
REQ-002 SHALL have parameter KBITS, default 256, meaning scalar width in bits.
REQ-003 SHALL have port i_clk, input, 1, meaning the single clock, rising-edge.
REQ-004 SHALL have port i_rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port i_start, input, 1, meaning a one-cycle request, accepted only in IDLE.
REQ-006 SHALL have ports i_k, input, KBITS, meaning the scalar; and i_x/i_y/i_z, input, W each, meaning base point P in projective coordinates.
REQ-007 SHALL have ports o_x/o_y/o_z, output, W each, meaning result kP; o_busy, output, 1; o_done, output, 1, meaning a one-cycle completion pulse.
REQ-008 SHALL have PointAdd master ports: o_pa_start, output, 1; o_pa_x1/y1/z1 and o_pa_x2/y2/z2, output, W each; i_pa_x3/y3/z3, input, W each; i_pa_finished, input, 1.

Function
REQ-009 SHALL compute kP by MSB-first double-and-add using the single external PointAdd unit for both doubling (R+R) and addition (R+P).
REQ-010 SHALL implement states IDLE, DBL_ISSUE, DBL_WAIT, ADD_ISSUE, ADD_WAIT, NEXT, DONE.
REQ-011 IDLE: on i_start=1, SHALL latch i_k and P, set R=(0,1,1), set bit counter to KBITS-1, and go to DBL_ISSUE.
REQ-012 DBL_ISSUE SHALL drive o_pa_start=1 for exactly one cycle with x1..z1=R and x2..z2=R, then go to DBL_WAIT.
REQ-013 DBL_WAIT: on i_pa_finished=1, SHALL load R from i_pa_x3..z3 and go to ADD_ISSUE if k[cnt]=1, else to NEXT.
REQ-014 ADD_ISSUE SHALL pulse o_pa_start for one cycle with operand 1=R and operand 2=latched P, then go to ADD_WAIT.
REQ-015 ADD_WAIT: on i_pa_finished=1, SHALL load R from the result and go to NEXT.
REQ-016 NEXT: if cnt=0, SHALL go to DONE; else SHALL decrement cnt and go to DBL_ISSUE; cnt SHALL never wrap.
REQ-017 DONE SHALL assert o_done=1 for one cycle and go to IDLE; o_x/o_y/o_z SHALL equal R and hold until the next accepted start.
REQ-018 o_busy SHALL be 1 in every state except IDLE.
REQ-019 i_start outside IDLE, and i_pa_finished outside DBL_WAIT/ADD_WAIT, SHALL be ignored.
REQ-020 PointAdd operand outputs SHALL remain stable from the start pulse until i_pa_finished is sampled.
REQ-021 k=0 SHALL yield R=(0,1,1) propagated through KBITS doublings and SHALL issue no additions.
REQ-022 Operation count SHALL be exactly KBITS doublings plus popcount(k) additions.

Reset
REQ-023 On i_rst_n=0, SHALL asynchronously enter IDLE with o_busy=0, o_done=0, o_pa_start=0, o_x=0, o_y=0, o_z=0, cnt=0, and all operand registers 0.
REQ-024 A reset during any active state SHALL abort the operation and produce no o_done; the integrator SHALL reset PointAdd from the same source.

Configuration
REQ-025 Macro SCALAR_MULT_CONST_TIME_EN: when defined, DBL_WAIT SHALL always go to ADD_ISSUE, and ADD_WAIT SHALL load R only if k[cnt]=1, otherwise discarding the result; the count becomes exactly 2*KBITS operations for every k.
REQ-026 Without SCALAR_MULT_CONST_TIME_EN, behaviour SHALL follow REQ-013/REQ-022, and no dummy additions SHALL be issued.

Verification
REQ-027 Use a stub PointAdd with fixed latency of 5 cycles; k=0 -> 256 o_pa_start pulses, all doublings, one o_done, o_busy low afterwards.
REQ-028 k=1 -> 257 pulses; the last is an addition with operand 2 = P; the result matches a golden model.
REQ-029 k=all ones -> 512 pulses alternating doubling/addition; the result matches the golden model.
REQ-030 With SCALAR_MULT_CONST_TIME_EN, k=0 -> 512 pulses, and the result equals the non-const-time k=0 result.
REQ-031 i_start pulsed mid-operation -> ignored, and latched k/P are unchanged; i_rst_n low during the 100th operation -> immediate IDLE, no o_done, and a restart completes correctly.
REQ-032 Integrate the real PointAdd with k=2 and a test point P -> output equals P+P computed standalone by PointAdd from the same R sequence.

Source files
------------

// File: rtl/scalar_mult_ctrl.sv
// scalar_mult_ctrl: MSB-first double-and-add controller for kP.
// Drives one external PointAdd unit for both doubling (R+R) and addition (R+P).
// Optional build macro SCALAR_MULT_CONST_TIME_EN: an addition is issued after
// every doubling and its result is kept only when the scalar bit is set, so
// the operation count is 2*KBITS for every scalar.
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_IDLE      | waiting for i_start; result registers hold last kP
// S_DBL_ISSUE | one-cycle PointAdd start with operands R, R
// S_DBL_WAIT  | waiting for PointAdd; result becomes new R
// S_ADD_ISSUE | one-cycle PointAdd start with operands R, P
// S_ADD_WAIT  | waiting for PointAdd; result becomes new R (if bit set)
// S_NEXT      | step to next lower scalar bit, or finish after bit 0
// S_DONE      | one-cycle o_done pulse, result registers valid
module scalar_mult_ctrl #(
  parameter int W     = 256,
  parameter int KBITS = 256
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [KBITS-1:0] i_k,
  input  logic [W-1:0]     i_x,
  input  logic [W-1:0]     i_y,
  input  logic [W-1:0]     i_z,
  output logic [W-1:0]     o_x,
  output logic [W-1:0]     o_y,
  output logic [W-1:0]     o_z,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pa_start,
  output logic [W-1:0]     o_pa_x1,
  output logic [W-1:0]     o_pa_y1,
  output logic [W-1:0]     o_pa_z1,
  output logic [W-1:0]     o_pa_x2,
  output logic [W-1:0]     o_pa_y2,
  output logic [W-1:0]     o_pa_z2,
  input  logic [W-1:0]     i_pa_x3,
  input  logic [W-1:0]     i_pa_y3,
  input  logic [W-1:0]     i_pa_z3,
  input  logic             i_pa_finished
);

  localparam int CW = (KBITS > 1) ? $clog2(KBITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DBL_ISSUE = 3'd1,
    S_DBL_WAIT  = 3'd2,
    S_ADD_ISSUE = 3'd3,
    S_ADD_WAIT  = 3'd4,
    S_NEXT      = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [KBITS-1:0] k_q;
  logic [W-1:0]     px;
  logic [W-1:0]     py;
  logic [W-1:0]     pz;
  logic [W-1:0]     rx;
  logic [W-1:0]     ry;
  logic [W-1:0]     rz;
  logic [CW-1:0]    cnt;
  logic             kbit;

  assign kbit = k_q[cnt];

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; i_start and i_pa_finished only matter in their own states.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (i_start) state_nxt = S_DBL_ISSUE;
      S_DBL_ISSUE: state_nxt = S_DBL_WAIT;
      S_DBL_WAIT: begin
        if (i_pa_finished) begin
`ifdef SCALAR_MULT_CONST_TIME_EN
          state_nxt = S_ADD_ISSUE;
`else
          state_nxt = kbit ? S_ADD_ISSUE : S_NEXT;
`endif
        end
      end
      S_ADD_ISSUE: state_nxt = S_ADD_WAIT;
      S_ADD_WAIT:  if (i_pa_finished) state_nxt = S_NEXT;
      S_NEXT:      state_nxt = (cnt == '0) ? S_DONE : S_DBL_ISSUE;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; operands come straight from R and the latched
  // P, so they cannot move while PointAdd is working (R only updates on finish).
  always_comb begin
    o_busy     = (state != S_IDLE);
    o_done     = (state == S_DONE);
    o_pa_start = (state == S_DBL_ISSUE) || (state == S_ADD_ISSUE);
    o_pa_x1    = rx;
    o_pa_y1    = ry;
    o_pa_z1    = rz;
    o_pa_x2    = px;
    o_pa_y2    = py;
    o_pa_z2    = pz;
    if ((state == S_DBL_ISSUE) || (state == S_DBL_WAIT)) begin
      o_pa_x2 = rx;
      o_pa_y2 = ry;
      o_pa_z2 = rz;
    end
  end

  // Datapath: operand latch, accumulator R, bit counter and result registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      k_q <= '0;
      px  <= '0;
      py  <= '0;
      pz  <= '0;
      rx  <= '0;
      ry  <= '0;
      rz  <= '0;
      cnt <= '0;
      o_x <= '0;
      o_y <= '0;
      o_z <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            k_q <= i_k;
            px  <= i_x;
            py  <= i_y;
            pz  <= i_z;
            rx  <= '0;
            ry  <= W'(1);
            rz  <= W'(1);
            cnt <= CW'(KBITS - 1);
          end
        end
        S_DBL_WAIT: begin
          if (i_pa_finished) begin
            rx <= i_pa_x3;
            ry <= i_pa_y3;
            rz <= i_pa_z3;
          end
        end
        S_ADD_WAIT: begin
`ifdef SCALAR_MULT_CONST_TIME_EN
          if (i_pa_finished && kbit) begin
`else
          if (i_pa_finished) begin
`endif
            rx <= i_pa_x3;
            ry <= i_pa_y3;
            rz <= i_pa_z3;
          end
        end
        S_NEXT: begin
          // Bit 0 finished: publish R so it is visible during the o_done cycle.
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            o_x <= rx;
            o_y <= ry;
            o_z <= rz;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Bench for scalar_mult_ctrl: stub PointAdd with 5-cycle latency, an
// algorithm-level double-and-add model that predicts every PointAdd request
// and the final result, and a single per-cycle compare process.
module tb_scalar_mult_ctrl;
  localparam int W     = 256;
  localparam int KBITS = 256;
`ifdef SCALAR_MULT_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
  } pt_t;

  typedef struct packed {
    pt_t a;
    pt_t b;
  } op_t;

  logic             i_clk;
  logic             i_rst_n;
  logic             i_start;
  logic [KBITS-1:0] i_k;
  logic [W-1:0]     i_x, i_y, i_z;
  logic [W-1:0]     o_x, o_y, o_z;
  logic             o_busy, o_done;
  logic             o_pa_start;
  logic [W-1:0]     o_pa_x1, o_pa_y1, o_pa_z1;
  logic [W-1:0]     o_pa_x2, o_pa_y2, o_pa_z2;
  logic [W-1:0]     i_pa_x3, i_pa_y3, i_pa_z3;
  logic             i_pa_finished;

  scalar_mult_ctrl #(.W(W), .KBITS(KBITS)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_k(i_k),
    .i_x(i_x), .i_y(i_y), .i_z(i_z),
    .o_x(o_x), .o_y(o_y), .o_z(o_z), .o_busy(o_busy), .o_done(o_done),
    .o_pa_start(o_pa_start),
    .o_pa_x1(o_pa_x1), .o_pa_y1(o_pa_y1), .o_pa_z1(o_pa_z1),
    .o_pa_x2(o_pa_x2), .o_pa_y2(o_pa_y2), .o_pa_z2(o_pa_z2),
    .i_pa_x3(i_pa_x3), .i_pa_y3(i_pa_y3), .i_pa_z3(i_pa_z3),
    .i_pa_finished(i_pa_finished)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Stand-in point operation: order-sensitive and distinguishes R+R from R+P.
  function automatic pt_t pa_f(input pt_t a, input pt_t b);
    pt_t r;
    r.x = (a.x << 1) + b.x + W'(1);
    r.y = a.y + b.y * W'(5);
    r.z = (a.z ^ {b.z[W-2:0], b.z[W-1]}) + W'(1);
    return r;
  endfunction

  // Shared state between stimulus, stub and checker (each variable has one writer).
  int   npass = 0;
  int   nchk  = 0;
  int   done_cnt = 0;
  int   ops_seen = 0;
  int   exp_lit  = 0;
  bit   spur     = 1'b0;

  // ---------------- stub PointAdd ----------------
  pt_t stub_a, stub_b, stub_r;
  bit  stub_abort;
  initial begin
    i_pa_finished = 1'b0;
    i_pa_x3 = '0; i_pa_y3 = '0; i_pa_z3 = '0;
    forever begin
      @(posedge i_clk); #1;
      i_pa_finished = 1'b0;
      if (i_rst_n && o_pa_start) begin
        stub_a = '{x: o_pa_x1, y: o_pa_y1, z: o_pa_z1};
        stub_b = '{x: o_pa_x2, y: o_pa_y2, z: o_pa_z2};
        stub_r = pa_f(stub_a, stub_b);
        stub_abort = 1'b0;
        for (int j = 0; j < 4; j++) begin
          @(posedge i_clk); #1;
          if (!i_rst_n) stub_abort = 1'b1;
        end
        if (!stub_abort && i_rst_n) begin
          i_pa_x3 = stub_r.x; i_pa_y3 = stub_r.y; i_pa_z3 = stub_r.z;
          i_pa_finished = 1'b1;
        end
      end else if (spur) begin
        i_pa_x3 = '1; i_pa_y3 = '1; i_pa_z3 = '1;
        i_pa_finished = 1'b1;
      end
    end
  end

  // ---------------- model + compare ----------------
  op_t  opq[$];
  op_t  e;
  pt_t  mr, mp, exp_res, last_res, pin, p011;
  logic [KBITS-1:0] mk;
  logic [3*W-1:0]   snap;
  bit   active = 1'b0;
  bit   was_active;
  bit   pend = 1'b0;
  bit   have_res = 1'b0;
  int   cyc = 0;

  task automatic chk(input bit ok, input string name, input string detail);
    nchk++;
    if (ok) npass++;
    else $display("FAIL %s: %s (t=%0t)", name, detail, $time);
  endtask

  initial begin
    p011 = '{x: W'(0), y: W'(1), z: W'(1)};
    pin  = pa_f(p011, p011);
    chk(pin.x == W'(1) && pin.y == W'(6) && pin.z == W'(4), "model_pin",
        $sformatf("got %0h/%0h/%0h need 1/6/4", pin.x[31:0], pin.y[31:0], pin.z[31:0]));
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        chk(!o_busy && !o_done && !o_pa_start && o_x == '0 && o_y == '0 && o_z == '0
            && o_pa_x1 == '0 && o_pa_y1 == '0 && o_pa_z1 == '0 && o_pa_x2 == '0,
            "reset_outs", $sformatf("busy=%b done=%b start=%b ox=%0h need all 0",
            o_busy, o_done, o_pa_start, o_x[63:0]));
        active = 1'b0; pend = 1'b0; have_res = 1'b0;
        opq.delete();
      end else begin
        was_active = active;
        chk(o_busy == active, "busy", $sformatf("got %b need %b", o_busy, active));
        if (o_pa_start) begin
          chk(!pend, "no_overlap", "start while previous op outstanding");
          if (opq.size() == 0) begin
            chk(1'b0, "extra_op", $sformatf("start pulse %0d not expected", ops_seen + 1));
          end else begin
            e = opq.pop_front();
            chk({o_pa_x1, o_pa_y1, o_pa_z1} == e.a && {o_pa_x2, o_pa_y2, o_pa_z2} == e.b,
                "pa_operands", $sformatf("op %0d got x1=%0h x2=%0h need x1=%0h x2=%0h",
                ops_seen + 1, o_pa_x1[63:0], o_pa_x2[63:0], e.a.x[63:0], e.b.x[63:0]));
          end
          ops_seen++;
          snap = {o_pa_x1, o_pa_y1, o_pa_z1};
          pend = 1'b1;
        end else if (pend) begin
          chk(snap == {o_pa_x1, o_pa_y1, o_pa_z1}, "operand_stable",
              $sformatf("x1 got %0h need %0h", o_pa_x1[63:0], snap[3*W-1 -: 64]));
          if (i_pa_finished) pend = 1'b0;
        end
        if (o_done) begin
          if (!was_active) begin
            chk(1'b0, "done_unexpected", "o_done with no operation in flight");
          end else begin
            chk(o_x == exp_res.x && o_y == exp_res.y && o_z == exp_res.z, "result",
                $sformatf("got x=%0h y=%0h z=%0h need x=%0h y=%0h z=%0h",
                o_x[63:0], o_y[63:0], o_z[63:0],
                exp_res.x[63:0], exp_res.y[63:0], exp_res.z[63:0]));
            chk(opq.size() == 0 && ops_seen == exp_lit, "op_count",
                $sformatf("got %0d ops (%0d left) need %0d", ops_seen, opq.size(), exp_lit));
            last_res = exp_res;
            have_res = 1'b1;
          end
          done_cnt++;
          active = 1'b0;
        end else if (!was_active && have_res) begin
          chk(o_x == last_res.x && o_y == last_res.y && o_z == last_res.z, "result_hold",
              $sformatf("got x=%0h need %0h", o_x[63:0], last_res.x[63:0]));
        end
        if (was_active && active) begin
          cyc++;
          if (cyc > 8000) begin
            chk(1'b0, "timeout", $sformatf("no o_done after %0d cycles", cyc));
            active = 1'b0;
            opq.delete();
          end
        end
        if (!was_active && i_start) begin
          mk = i_k;
          mp = '{x: i_x, y: i_y, z: i_z};
          mr = p011;
          opq.delete();
          for (int i = KBITS - 1; i >= 0; i--) begin
            opq.push_back('{a: mr, b: mr});
            mr = pa_f(mr, mr);
            if (mk[i] || CT) begin
              opq.push_back('{a: mr, b: mp});
              if (mk[i]) mr = pa_f(mr, mp);
            end
          end
          exp_res  = mr;
          ops_seen = 0;
          cyc      = 0;
          have_res = 1'b0;
          active   = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run(input logic [KBITS-1:0] k, input pt_t p, input int lit, input bit poke);
    int d0;
    exp_lit = lit;
    @(posedge i_clk); #1;
    i_k = k; i_x = p.x; i_y = p.y; i_z = p.z;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    if (poke) begin
      repeat (40) @(posedge i_clk);
      #1;
      i_k = ~k; i_x = p.x + W'(7); i_y = ~p.y; i_z = p.z ^ W'(3);
      i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
    end
    d0 = done_cnt;
    for (int n = 0; n < 9000 && done_cnt == d0; n++) @(posedge i_clk);
    repeat (4) @(posedge i_clk);
  endtask

  pt_t p1, p2, p3;
  logic [KBITS-1:0] kpat, kall;

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_k = '0; i_x = '0; i_y = '0; i_z = '0;
    p1 = '{x: W'(64'h1234_5678_9abc_def0), y: W'(64'h0fed_cba9_8765_4321), z: W'(3)};
    p2 = '{x: W'(32'hdead_beef), y: W'(7), z: W'(1)};
    p3 = '{x: W'(5), y: W'(64'h1111_2222_3333_4444), z: W'(9)};
    kpat = {8{32'ha5c3_0f11}};
    kall = '1;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    repeat (3) @(posedge i_clk);
    #1 spur = 1'b1;
    repeat (3) @(posedge i_clk);
    #1 spur = 1'b0;
    repeat (3) @(posedge i_clk);

    run('0, p1, CT ? 2 * KBITS : KBITS, 1'b0);
    run(KBITS'(1), p2, CT ? 2 * KBITS : KBITS + 1, 1'b0);
    run(kall, p3, 2 * KBITS, 1'b1);
    run(kpat, p1, CT ? 2 * KBITS : KBITS + $countones(kpat), 1'b0);

    // Abort during the 100th PointAdd operation.
    exp_lit = 0;
    @(posedge i_clk); #1;
    i_k = kpat; i_x = p2.x; i_y = p2.y; i_z = p2.z;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    for (int n = 0; n < 9000 && ops_seen < 100; n++) @(posedge i_clk);
    #1 i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    repeat (20) @(posedge i_clk);

    run(KBITS'(2), p3, CT ? 2 * KBITS : KBITS + 1, 1'b0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
